// File: rtl/cas_lock_pkg.sv
// Shared definitions for the key loader: key/check widths and loader FSM states.
package cas_lock_pkg;

    localparam int KEY_W = 64;
    localparam int CHK_W = KEY_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_KEY,
        SHIFT_CHK,
        COMMIT
    } load_state_t;

endpackage

// File: rtl/cas_key_chk.sv
// Byte-parity generator: parity[j] is the XOR of bits 8j..8j+7 of the shadow key.
module cas_key_chk #(
    parameter int KEY_W = 64,
    parameter int CHK_W = 8
) (
    input  logic [KEY_W-1:0] shadow,
    output logic [CHK_W-1:0] parity
);

    for (genvar j = 0; j < CHK_W; j++) begin : g_byte
        assign parity[j] = ^shadow[8*j +: 8];
    end

endmodule

// File: rtl/cas_key_loader.sv
// Serial key loader: shifts a key frame into a shadow register, checks byte parity,
// and only then commits the key to the registered keyinput bus.
module cas_key_loader #(
    parameter int KEY_W = cas_lock_pkg::KEY_W,
    parameter int CHK_W = cas_lock_pkg::CHK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             zeroize,
    input  logic             load_start,
    input  logic             key_sdi,
    input  logic             key_sdi_valid,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_valid,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err
);

    import cas_lock_pkg::*;

    localparam int CNT_W  = $clog2(KEY_W);
    localparam int CIDX_W = (CHK_W > 1) ? $clog2(CHK_W) : 1;
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHK_W - 1);

    load_state_t       state;
    logic [KEY_W-1:0]  shadow;
    logic [CNT_W-1:0]  count;
    logic              err_flag;
    logic [CHK_W-1:0]  parity;
    logic [CIDX_W-1:0] chk_idx;

    assign chk_idx = count[CIDX_W-1:0];

    cas_key_chk #(
        .KEY_W (KEY_W),
        .CHK_W (CHK_W)
    ) u_chk (
        .shadow (shadow),
        .parity (parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            keyinput  <= '0;
            shadow    <= '0;
            count     <= '0;
            err_flag  <= 1'b0;
            key_valid <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            if (zeroize) begin
                state     <= IDLE;
                keyinput  <= '0;
                key_valid <= 1'b0;
                load_busy <= 1'b0;
                shadow    <= '0;
                count     <= '0;
                err_flag  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (load_start) begin
                            state     <= SHIFT_KEY;
                            shadow    <= '0;
                            count     <= '0;
                            err_flag  <= 1'b0;
                            load_busy <= 1'b1;
                        end
                    end
                    SHIFT_KEY, SHIFT_CHK: begin
                        // A restart discards any bit presented in the same cycle.
                        if (load_start) begin
                            state     <= SHIFT_KEY;
                            shadow    <= '0;
                            count     <= '0;
                            err_flag  <= 1'b0;
                            load_busy <= 1'b1;
                        end else if (key_sdi_valid) begin
                            if (state == SHIFT_KEY) begin
                                shadow[count] <= key_sdi;
                                if (count == KEY_LAST) begin
                                    count <= '0;
                                    state <= SHIFT_CHK;
                                end else begin
                                    count <= count + 1'b1;
                                end
                            end else begin
                                if (key_sdi != parity[chk_idx]) begin
                                    err_flag <= 1'b1;
                                end
                                if (count == CHK_LAST) begin
                                    count     <= '0;
                                    state     <= COMMIT;
                                    load_busy <= 1'b0;
                                end else begin
                                    count <= count + 1'b1;
                                end
                            end
                        end
                    end
                    COMMIT: begin
                        if (err_flag) begin
                            load_err <= 1'b1;
                        end else begin
                            keyinput  <= shadow;
                            key_valid <= 1'b1;
                            load_done <= 1'b1;
                        end
                        err_flag <= 1'b0;
                        if (load_start) begin
                            state     <= SHIFT_KEY;
                            shadow    <= '0;
                            count     <= '0;
                            load_busy <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cas_key_loader.sv
// Directed self-checking bench for cas_key_loader: load, parity error, abort,
// stalls, zeroize and mid-frame reset.
module tb_cas_key_loader;

    import cas_lock_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        zeroize;
    logic        load_start;
    logic        key_sdi;
    logic        key_sdi_valid;
    logic [63:0] keyinput;
    logic        key_valid;
    logic        load_busy;
    logic        load_done;
    logic        load_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;
    int err_count  = 0;
    bit busy_gap = 1'b0;

    localparam logic [63:0] KEY_A = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] KEY_B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] KEY_C = 64'h0F1E_2D3C_4B5A_6978;
    localparam logic [63:0] KEY_D = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KEY_E = 64'h8000_0000_0000_0001;

    cas_key_loader dut (
        .clk           (clk),
        .rst           (rst),
        .zeroize       (zeroize),
        .load_start    (load_start),
        .key_sdi       (key_sdi),
        .key_sdi_valid (key_sdi_valid),
        .keyinput      (keyinput),
        .key_valid     (key_valid),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done) done_count++;
        if (load_err)  err_count++;
    end

    function automatic logic [7:0] par(input logic [63:0] k);
        logic [7:0] p;
        for (int j = 0; j < 8; j++) p[j] = ^k[8*j +: 8];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_bits(input logic [71:0] frame, input int lo, input int hi, input int stall_max);
        int stalls;
        for (int i = lo; i <= hi; i++) begin
            stalls = int'($urandom_range(stall_max, 0));
            repeat (stalls) begin
                if (!load_busy) busy_gap = 1'b1;
                tick();
            end
            if (!load_busy) busy_gap = 1'b1;
            key_sdi       = frame[i];
            key_sdi_valid = 1'b1;
            tick();
            key_sdi_valid = 1'b0;
            key_sdi       = 1'b0;
        end
    endtask

    task automatic load_key(input logic [63:0] k);
        start_frame();
        send_bits({par(k), k}, 0, 71, 0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++; if (keyinput !== 64'h0) begin n_fail++; $display("FAIL reset_keyinput got %h want 0", keyinput); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
        n_checks++; if (load_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", load_busy); end
        n_checks++; if ({load_done, load_err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got %b want 00", {load_done, load_err}); end
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        start_frame();
        n_checks++; if (load_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b want 1", load_busy); end
        send_bits({8'hFF, KEY_D}, 0, 71, 0);
        n_checks++; if ({load_done, load_busy} !== 2'b00) begin n_fail++; $display("FAIL basic_cycle72 done,busy got %b want 00", {load_done, load_busy}); end
        tick();
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_cycle73 got %b want 1", load_done); end
        n_checks++; if (keyinput !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL basic_keyinput got %h want 0123456789abcdef", keyinput); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL basic_key_valid got %b want 1", key_valid); end
        tick();
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_single got %b want 0", load_done); end
    endtask

    task automatic test_bad_check();
        int eb;
        eb = err_count;
        start_frame();
        send_bits({8'hF7, KEY_D}, 0, 71, 0);
        tick();
        n_checks++; if ({load_err, load_done} !== 2'b10) begin n_fail++; $display("FAIL badchk_pulse err,done got %b want 10", {load_err, load_done}); end
        tick();
        tick();
        n_checks++; if (err_count - eb !== 1) begin n_fail++; $display("FAIL badchk_err_count got %0d want 1", err_count - eb); end
        n_checks++; if (keyinput !== 64'h0) begin n_fail++; $display("FAIL badchk_keyinput got %h want 0", keyinput); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL badchk_key_valid got %b want 0", key_valid); end
    endtask

    task automatic test_abort_restart();
        int db, eb;
        load_key(KEY_A);
        tick();
        db = done_count;
        eb = err_count;
        start_frame();
        send_bits({par(KEY_B), KEY_B}, 0, 29, 0);
        n_checks++; if (keyinput !== KEY_A) begin n_fail++; $display("FAIL abort_midframe_keyinput got %h want %h", keyinput, KEY_A); end
        load_start = 1'b1; key_sdi = 1'b1; key_sdi_valid = 1'b1;
        tick();
        load_start = 1'b0; key_sdi = 1'b0; key_sdi_valid = 1'b0;
        send_bits({par(KEY_C), KEY_C}, 0, 71, 0);
        tick();
        tick();
        n_checks++; if (keyinput !== KEY_C) begin n_fail++; $display("FAIL abort_keyinput got %h want %h", keyinput, KEY_C); end
        n_checks++; if (done_count - db !== 1) begin n_fail++; $display("FAIL abort_done_count got %0d want 1", done_count - db); end
        n_checks++; if (err_count - eb !== 0) begin n_fail++; $display("FAIL abort_err_count got %0d want 0", err_count - eb); end
    endtask

    task automatic test_stalls();
        int waited;
        busy_gap = 1'b0;
        start_frame();
        send_bits({8'hFF, KEY_D}, 0, 71, 5);
        waited = 0;
        while (!load_done && waited < 10) begin
            tick();
            waited++;
        end
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL stall_done got %b want 1 after %0d cycles", load_done, waited); end
        n_checks++; if (keyinput !== KEY_D) begin n_fail++; $display("FAIL stall_keyinput got %h want %h", keyinput, KEY_D); end
        n_checks++; if (busy_gap !== 1'b0) begin n_fail++; $display("FAIL stall_busy_gap got %b want 0", busy_gap); end
        n_checks++; if (waited !== 1) begin n_fail++; $display("FAIL stall_latency got %0d want 1", waited); end
    endtask

    task automatic test_zeroize();
        int db, eb;
        load_key(KEY_A);
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL zero_pre_valid got %b want 1", key_valid); end
        tick();
        db = done_count;
        eb = err_count;
        start_frame();
        send_bits({par(KEY_B), KEY_B}, 0, 39, 0);
        zeroize = 1'b1; key_sdi = 1'b1; key_sdi_valid = 1'b1;
        tick();
        zeroize = 1'b0; key_sdi = 1'b0; key_sdi_valid = 1'b0;
        n_checks++; if (keyinput !== 64'h0) begin n_fail++; $display("FAIL zero_keyinput got %h want 0", keyinput); end
        n_checks++; if ({key_valid, load_busy} !== 2'b00) begin n_fail++; $display("FAIL zero_valid_busy got %b want 00", {key_valid, load_busy}); end
        n_checks++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL zero_state got %0d want %0d", dut.state, IDLE); end
        send_bits({par(KEY_B), KEY_B}, 40, 71, 0);
        tick();
        tick();
        n_checks++; if ((done_count - db) + (err_count - eb) !== 0) begin n_fail++; $display("FAIL zero_pulses got %0d want 0", (done_count - db) + (err_count - eb)); end
        n_checks++; if (keyinput !== 64'h0) begin n_fail++; $display("FAIL zero_idle_keyinput got %h want 0", keyinput); end
    endtask

    task automatic test_reset_mid_frame();
        int db, eb;
        load_key(KEY_A);
        tick();
        db = done_count;
        eb = err_count;
        start_frame();
        send_bits({par(KEY_B), KEY_B}, 0, 69, 0);
        rst = 1'b1; key_sdi_valid = 1'b1;
        tick();
        rst = 1'b0; key_sdi_valid = 1'b0;
        n_checks++; if (keyinput !== 64'h0) begin n_fail++; $display("FAIL rstmid_keyinput got %h want 0", keyinput); end
        n_checks++; if ({key_valid, load_busy, load_done, load_err} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_flags got %b want 0000", {key_valid, load_busy, load_done, load_err}); end
        tick();
        tick();
        n_checks++; if ((done_count - db) + (err_count - eb) !== 0) begin n_fail++; $display("FAIL rstmid_pulses got %0d want 0", (done_count - db) + (err_count - eb)); end
        load_key(KEY_E);
        n_checks++; if (keyinput !== KEY_E) begin n_fail++; $display("FAIL rstmid_reload got %h want %h", keyinput, KEY_E); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reload_valid got %b want 1", key_valid); end
    endtask

    initial begin
        rst = 1'b1;
        zeroize = 1'b0;
        load_start = 1'b0;
        key_sdi = 1'b0;
        key_sdi_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_basic_load();
        test_reset();
        test_bad_check();
        test_abort_restart();
        test_stalls();
        test_zeroize();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cas_key_loader.md
CAS_KEY_LOADER -- requirements
Module: cas_key_loader

Interface
REQ-001 Parameter KEY_W, default 64, width of the locking key bus.
REQ-002 Parameter CHK_W, default 8, number of byte-parity check bits (KEY_W/8).
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 zeroize  input  1  clears the active key and aborts any load in progress.
REQ-006 load_start  input  1  one-cycle pulse that begins a new key frame.
REQ-007 key_sdi  input  1  serial frame bit.
REQ-008 key_sdi_valid  input  1  key_sdi is sampled only when this is high.
REQ-009 keyinput  output  KEY_W  active key; bit i drives keyinput_i of the locked netlist.
REQ-010 key_valid  output  1  high while keyinput holds a successfully committed key.
REQ-011 load_busy  output  1  high while a frame is being received.
REQ-012 load_done  output  1  one-cycle pulse on a successful commit.
REQ-013 load_err  output  1  one-cycle pulse on a check failure.

Function
REQ-014 Frame format: KEY_W key bits, bit 0 first, then CHK_W check bits, check bit j first; check bit j = XOR of key bits 8j..8j+7.
REQ-015 FSM states: IDLE, SHIFT_KEY, SHIFT_CHK, COMMIT.
REQ-016 IDLE -> SHIFT_KEY on load_start; the bit counter and shadow register clear, and load_busy rises the next cycle.
REQ-017 SHIFT_KEY: each accepted bit is written to shadow[count]; after bit KEY_W-1 the counter resets and the FSM goes to SHIFT_CHK.
REQ-018 SHIFT_CHK: each accepted bit is compared against the computed parity for byte count; any mismatch sets a sticky error flag; after bit CHK_W-1 the FSM goes to COMMIT.
REQ-019 COMMIT lasts exactly one cycle, then IDLE; load_busy is low in COMMIT.
REQ-020 In COMMIT with no error: keyinput <= shadow, key_valid <= 1 and load_done is pulsed, all on the same edge; latency is 1 cycle after the last check bit is accepted.
REQ-021 In COMMIT with an error: load_err is pulsed, and keyinput and key_valid are unchanged.
REQ-022 A cycle with key_sdi_valid low does not advance the counter (stall, no timeout).
REQ-023 key_sdi_valid in IDLE or COMMIT is ignored.
REQ-024 load_start while busy restarts the frame: shadow, counter and error flag clear, and the state goes to SHIFT_KEY; no done or err pulse is produced for the aborted frame.
REQ-025 load_start and key_sdi_valid in the same cycle: the restart wins and that bit is discarded.
REQ-026 zeroize: on the next edge keyinput <= 0, key_valid <= 0, and the FSM goes to IDLE with no pulses; it overrides load_start and data.
REQ-027 Priority order: rst > zeroize > load_start > key_sdi_valid.
REQ-028 keyinput is driven only from a register and never from the shadow register mid-load (no glitching into the locked logic).
REQ-029 Counter width is clog2(KEY_W) bits; the counter never wraps beyond its terminal value.

Reset
REQ-030 On rst: state IDLE, keyinput 0, shadow 0, counter 0, error flag 0.
REQ-031 On rst: key_valid 0, load_busy 0, load_done 0, load_err 0.
REQ-032 rst mid-frame discards the frame with no pulses produced.

Structure
REQ-033 The shared package cas_lock_pkg holds KEY_W, CHK_W and the loader state enum.
REQ-034 One sub-module, cas_key_chk, computes the byte-parity vector from the shadow register.
REQ-035 The block contains no latches and no combinational path from any input to keyinput.

Verification
REQ-036 After reset, send the frame for key 64'h0123_4567_89AB_CDEF with correct parity and no stalls -> load_done at cycle 73 after load_start, keyinput = 64'h0123456789ABCDEF, key_valid = 1.
REQ-037 Send the same frame with check bit 3 flipped -> load_err pulses once, keyinput stays 0, key_valid = 0.
REQ-038 With key A committed, start a frame for key B, abort after 30 bits with load_start, then complete key C -> keyinput = C, and exactly one load_done occurs after the abort.
REQ-039 Insert random stalls of 0-5 cycles on key_sdi_valid -> result identical to the unstalled run; load_busy stays high throughout the frame.
REQ-040 With key_valid = 1, pulse zeroize at bit 40 of a new frame -> keyinput = 0, key_valid = 0, state IDLE, and no pulses.
REQ-041 Assert rst at bit 70 -> all outputs equal their reset values and the following full frame loads correctly.
